matrix_index_counter: RTL

- Parametrised two-level (row/column) index counter. It is the next generation of the single enable counter.
- Walks every element of a ROWS x COLS matrix exactly once, in either row-major or column-major order.
- Uses a start/busy/done handshake and supports per-cycle stall.
- Drives address generation for the matrix datapath and read/write sequencers.

---
 rtl/matrix_index_counter_pkg.sv | 25 ++
 rtl/matrix_index_counter_mod_counter.sv | 46 ++++
 rtl/matrix_index_counter.sv | 112 +++++++++++
 3 files changed

// File: rtl/matrix_index_counter_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix index counter:
//   - state_t    : FSM state encoding (IDLE / RUN / DONE)
//   - ORDER_ROW  : traversal order bit for row-major (column index is inner)
//   - ORDER_COL  : traversal order bit for column-major (row index is inner)
//   - clog2_min1 : $clog2 clamped to a minimum of 1, so that a dimension of
//                  size 1 still gets a legal 1-bit index.
// -----------------------------------------------------------------------------
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ORDER_ROW = 1'b0;
    localparam logic ORDER_COL = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_index_counter_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-MOD up-counter with synchronous clear and count enable.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset (count -> 0)
//   clear   : synchronous clear (priority over enable)
//   enable  : advance by one this cycle
//   count   : current count, always in 0..MOD-1
//   wrap    : enable & (count == MOD-1); the counter returns to 0 next cycle
//   at_max  : count == MOD-1, independent of enable
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         at_max
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic [W-1:0] r_count;

    // Wrap is decided by compare so non-power-of-two moduli never overflow
    // past MOD-1.
    assign at_max = (r_count == MAX);
    assign wrap   = enable & at_max;
    assign count  = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= at_max ? '0 : (r_count + 1'b1);
        end
    end

endmodule

// File: rtl/matrix_index_counter.sv
// -----------------------------------------------------------------------------
// matrix_index_counter
// Walks every (row, col) of a ROWS x COLS matrix exactly once, row-major or
// column-major, one element per non-stalled RUN cycle.
//
// Handshake: a one-cycle start is accepted only in IDLE (col_major is latched
// at that moment); busy is high for every RUN cycle; valid = busy & ~stall
// marks the cycle in which (row_idx, col_idx) is presented; last accompanies
// the final valid element; done pulses for one cycle right after it. start
// while busy or during done is dropped, not queued.
//
// Ports:
//   clk, reset (async active-low)
//   start, col_major, stall          : control inputs
//   row_idx, col_idx                 : registered indices
//   valid, last, busy, done          : status outputs
//   o_dbg_state                      : current FSM state
// -----------------------------------------------------------------------------
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter  int ROWS  = 4,
    parameter  int COLS  = 4,
    localparam int ROW_W = clog2_min1(ROWS),
    localparam int COL_W = clog2_min1(COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             col_major,
    input  logic             stall,
    output logic [ROW_W-1:0] row_idx,
    output logic [COL_W-1:0] col_idx,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done,
    output state_t           o_dbg_state
);

    state_t r_state;
    state_t w_next_state;
    logic   r_order;

    logic w_adv;
    logic w_clear;
    logic w_row_en, w_col_en;
    logic w_row_wrap, w_col_wrap;
    logic w_row_at_max, w_col_at_max;
    logic w_last;

    assign w_adv   = (r_state == RUN) & ~stall;
    assign w_clear = (r_state == IDLE);

    // Enables are built from the at_max flags rather than the other counter's
    // wrap output, which keeps the order mux free of a combinational loop.
    assign w_row_en = (r_order == ORDER_COL) ? w_adv : (w_adv & w_col_at_max);
    assign w_col_en = (r_order == ORDER_COL) ? (w_adv & w_row_at_max) : w_adv;

    mod_counter #(.MOD(ROWS), .W(ROW_W)) u_row_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .enable (w_row_en),
        .count  (row_idx),
        .wrap   (w_row_wrap),
        .at_max (w_row_at_max)
    );

    mod_counter #(.MOD(COLS), .W(COL_W)) u_col_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .enable (w_col_en),
        .count  (col_idx),
        .wrap   (w_col_wrap),
        .at_max (w_col_at_max)
    );

    // Both counters wrapping in the same cycle happens only on the final
    // element, and both land back on 0 for the next traversal.
    assign w_last = w_row_wrap & w_col_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_order <= ORDER_ROW;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && start) begin
                r_order <= col_major;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign valid       = w_adv;
    assign last        = w_last;
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign o_dbg_state = r_state;

endmodule
